// File: rtl/svc_uart_rx_mon.sv
`default_nettype none
// ============================================================================
// Module      : svc_uart_rx_mon
// Description : UART 8N1 receiver/monitor producing a valid/ready byte stream
//               with framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module svc_uart_rx_mon #(
    parameter int CLOCK_FREQ_MHZ = 25,
    parameter int BAUD_RATE      = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int C_CLKS_PER_BIT = (CLOCK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
    localparam int C_HALF_BIT     = C_CLKS_PER_BIT / 2;
    localparam int C_CNT_W        = $clog2(C_CLKS_PER_BIT + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_BIT_END  = C_CNT_W'(C_CLKS_PER_BIT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_HALF_END = C_CNT_W'(C_HALF_BIT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE      = C_CNT_W'(1);

    localparam logic [2:0] S_ARM   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic               r_sync1;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_m_valid;
    logic [7:0]         r_m_data;
    logic               r_framing_err;
    logic               r_overrun;

    logic [2:0]         w_state_nxt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_byte_done;
    logic               w_frame_bad;

    // Synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_ARM;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_done   = 1'b0;
        w_frame_bad   = 1'b0;
        case (r_state)
            S_ARM: begin
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == C_CNT_HALF_END) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_cnt == C_CNT_BIT_END) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_STOP: begin
                if (r_cnt == C_CNT_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Line may be stuck low; rearm rather than hunt for a start
                        w_frame_bad = 1'b1;
                        w_state_nxt = S_ARM;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_ARM;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= 8'd0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= w_frame_bad;
            r_overrun     <= 1'b0;
            if (w_byte_done) begin
                if (!r_m_valid || m_ready) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_shift;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_svc_uart_rx_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_svc_uart_rx_mon
// Description : Directed self-checking bench for the UART receiver/monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svc_uart_rx_mon;

    localparam int C_BIT = 217;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         n_acc  = 0;
    int         n_fe   = 0;
    int         n_ov   = 0;
    int         n_stab = 0;
    int         n_both = 0;
    logic [7:0] acc_q[$];
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic [7:0] p_data  = 8'd0;

    int acc0, fe0, ov0;

    svc_uart_rx_mon dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Record accepted bytes, error pulses and handshake-stability violations
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                acc_q.push_back(m_data);
                n_acc++;
            end
            if (framing_err) n_fe++;
            if (overrun) n_ov++;
            if (framing_err && overrun) n_both++;
            if (p_valid && !p_ready && m_valid && (m_data !== p_data)) n_stab++;
        end
        p_valid = m_valid;
        p_ready = m_ready;
        p_data  = m_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        tick(C_BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(C_BIT);
        end
        uart_rx = stop;
        tick(C_BIT);
        uart_rx = 1'b1;
    endtask

    task automatic mark();
        acc0 = n_acc;
        fe0  = n_fe;
        ov0  = n_ov;
    endtask

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        m_ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_fe", 32'(framing_err), 32'd0);
        chk("rst_ov", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(10);

        // Single byte 0x55
        mark();
        send_byte(8'h55, 1'b1);
        tick(5);
        @(negedge clk);
        chk("t1_count", 32'(n_acc - acc0), 32'd1);
        chk("t1_data", 32'(acc_q[acc0]), 32'h55);
        chk("t1_fe", 32'(n_fe - fe0), 32'd0);
        chk("t1_ov", 32'(n_ov - ov0), 32'd0);

        // Back-to-back 0x00, 0xFF
        mark();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(5);
        @(negedge clk);
        chk("t2_count", 32'(n_acc - acc0), 32'd2);
        chk("t2_data0", 32'(acc_q[acc0]), 32'h00);
        chk("t2_data1", 32'(acc_q[acc0+1]), 32'hFF);

        // 50-cycle glitch is rejected at the start-bit midpoint
        mark();
        uart_rx = 1'b0;
        tick(10);
        @(negedge clk);
        chk("t3_busy_in", 32'(busy), 32'd1);
        tick(40);
        uart_rx = 1'b1;
        tick(100);
        @(negedge clk);
        chk("t3_busy_out", 32'(busy), 32'd0);
        chk("t3_count", 32'(n_acc - acc0), 32'd0);

        // Framing error then recovery
        mark();
        send_byte(8'hA5, 1'b0);
        tick(C_BIT);
        @(negedge clk);
        chk("t4_fe", 32'(n_fe - fe0), 32'd1);
        chk("t4_count0", 32'(n_acc - acc0), 32'd0);
        send_byte(8'h3C, 1'b1);
        tick(5);
        @(negedge clk);
        chk("t4_count1", 32'(n_acc - acc0), 32'd1);
        chk("t4_data", 32'(acc_q[acc0]), 32'h3C);

        // Overrun while the consumer stalls
        mark();
        m_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(5);
        @(negedge clk);
        chk("t5_valid", 32'(m_valid), 32'd1);
        chk("t5_data", 32'(m_data), 32'h11);
        chk("t5_ov", 32'(n_ov - ov0), 32'd1);
        chk("t5_fe", 32'(n_fe - fe0), 32'd0);
        chk("t5_count0", 32'(n_acc - acc0), 32'd0);
        tick(1);
        m_ready = 1'b1;
        tick(1);
        @(negedge clk);
        chk("t5_valid_clr", 32'(m_valid), 32'd0);
        chk("t5_count1", 32'(n_acc - acc0), 32'd1);
        chk("t5_acc", 32'(acc_q[acc0]), 32'h11);

        // Reset during data bit 4 of 0x96, then a clean 0xC3
        mark();
        uart_rx = 1'b0;
        tick(C_BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i == 1 || i == 2) ? 1'b1 : 1'b0;
            tick(C_BIT);
        end
        uart_rx = 1'b1;
        tick(100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_data", 32'(m_data), 32'd0);
        chk("t6_fe", 32'(framing_err), 32'd0);
        chk("t6_ov", 32'(overrun), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        tick(2 * C_BIT);
        send_byte(8'hC3, 1'b1);
        tick(5);
        @(negedge clk);
        chk("t6_count", 32'(n_acc - acc0), 32'd1);
        chk("t6_acc", 32'(acc_q[acc0]), 32'hC3);

        chk("stable_data", 32'(n_stab), 32'd0);
        chk("fe_ov_same_cycle", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
